// File: rtl/turn_signal_seq_pkg.sv
// Shared types for the turn-signal sequencer and downstream lamp stages:
// FSM state encoding, lamp patterns and the state-to-lamp decode.
package turn_signal_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    L1,
    L2,
    L3,
    R1,
    R2,
    R3,
    ERR_ON,
    ERR_OFF
  } state_e;

  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMP_OFF = 3'b000;
  localparam lamp_t LAMP_P1  = 3'b001;
  localparam lamp_t LAMP_P2  = 3'b011;
  localparam lamp_t LAMP_P3  = 3'b111;

  typedef struct packed {
    lamp_t left;
    lamp_t right;
    logic  error;
  } lamps_t;

  localparam lamps_t LAMPS_DARK = '{left: LAMP_OFF, right: LAMP_OFF, error: 1'b0};

  function automatic lamps_t decode_state(input state_e st);
    lamps_t l;
    l = LAMPS_DARK;
    case (st)
      L1:      l.left  = LAMP_P1;
      L2:      l.left  = LAMP_P2;
      L3:      l.left  = LAMP_P3;
      R1:      l.right = LAMP_P1;
      R2:      l.right = LAMP_P2;
      R3:      l.right = LAMP_P3;
      ERR_ON: begin
        l.left  = LAMP_P3;
        l.right = LAMP_P3;
        l.error = 1'b1;
      end
      ERR_OFF: l.error = 1'b1;
      default: l = LAMPS_DARK;
    endcase
    return l;
  endfunction

  function automatic logic is_error_state(input state_e st);
    return (st == ERR_ON) || (st == ERR_OFF);
  endfunction

endpackage

// File: rtl/turn_signal_seq_sync.sv
// Multi-flop synchronizer for one asynchronous switch input into the
// sequencer clock domain; cleared by the synchronous reset.
module sig_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sig_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/turn_signal_seq.sv
// Turn-signal sequencer: synchronizes the two switches and steps a lamp
// pattern FSM on each upstream tick; lamp outputs are registered.
module turn_signal_seq
  import turn_signal_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       left_in,
  input  logic       right_in,
  output logic [2:0] left_lights,
  output logic [2:0] right_lights,
  output logic       error
);

  logic   sl;
  logic   sr;
  state_e state_q;
  state_e state_d;
  lamps_t lamps_q;
  lamps_t lamps_d;

  sig_sync #(.STAGES(SYNC_STAGES)) u_sync_left (
    .clk  (CLOCK_50),
    .reset(reset),
    .d    (left_in),
    .q    (sl)
  );

  sig_sync #(.STAGES(SYNC_STAGES)) u_sync_right (
    .clk  (CLOCK_50),
    .reset(reset),
    .d    (right_in),
    .q    (sr)
  );

  // NOTE: state_d gets a default before any branch so the combinational block cannot infer a latch.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      if (sl && sr && !is_error_state(state_q)) begin
        state_d = ERR_ON;
      end else begin
        case (state_q)
          IDLE: begin
            if (sl)      state_d = L1;
            else if (sr) state_d = R1;
            else         state_d = IDLE;
          end
          L1:      state_d = sl ? L2 : IDLE;
          L2:      state_d = sl ? L3 : IDLE;
          L3:      state_d = sl ? L1 : IDLE;
          R1:      state_d = sr ? R2 : IDLE;
          R2:      state_d = sr ? R3 : IDLE;
          R3:      state_d = sr ? R1 : IDLE;
          ERR_ON:  state_d = (sl && sr) ? ERR_OFF : IDLE;
          ERR_OFF: state_d = (sl && sr) ? ERR_ON : IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Lamps are decoded from the next state so the registered outputs always
  // match the state register on the same edge.
  always_comb begin
    lamps_d = decode_state(state_d);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      lamps_q <= LAMPS_DARK;
    end else begin
      state_q <= state_d;
      lamps_q <= lamps_d;
    end
  end

  assign left_lights  = lamps_q.left;
  assign right_lights = lamps_q.right;
  assign error        = lamps_q.error;

endmodule
